bank_arbiter: RTL

BANK_ARBITER -- requirements
Module: bank_arbiter

---
 rtl/bank_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bank_arbiter.sv
// Ping-pong bank arbiter: fills one bank from acquisition while the other drains to readout.
// Optional macro BANK_ARB_DROP_CNT_EN adds an 8-bit saturating drop_count output.
module bank_arbiter #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_req,
    input  logic             event_end,
    input  logic             rd_req,
    output logic             we,
    output logic [IDX_W:0]   addr_in,
    output logic             re,
    output logic [IDX_W:0]   addr_out,
    output logic             rd_valid,
    output logic [1:0]       bank_full,
    output logic [IDX_W-1:0] idx_final,
    output logic             sending_data,
    output logic             overflow
`ifdef BANK_ARB_DROP_CNT_EN
    ,
    output logic [7:0]       drop_count
`endif
);

    localparam logic [IDX_W-1:0] IDX_MAX = '1;
    localparam logic [IDX_W-1:0] IDX_ONE = 1;

    typedef enum logic [1:0] {IDLE, SELECT, READ, RELEASE} state_t;

    state_t           state, state_nxt;
    logic             wbank, rbank, order;
    logic [IDX_W-1:0] widx, ridx;
    logic [IDX_W-1:0] last_idx [2];
    logic             write_ok, drop, close_bank, release_bank, sel_bank;
    logic [1:0]       full_nxt;

    assign write_ok     = wr_req & ~bank_full[wbank];
    assign drop         = wr_req & bank_full[wbank];
    // A same-cycle write at index 0 still lets event_end close the bank.
    assign close_bank   = (write_ok & (widx == IDX_MAX)) |
                          (event_end & ((widx != '0) | write_ok));
    assign release_bank = (state == RELEASE);
    assign sel_bank     = (bank_full == 2'b11) ? order : bank_full[1];

    assign we           = reset & write_ok;
    assign addr_in      = {wbank, widx};
    assign re           = reset & (state == READ) & rd_req;
    assign addr_out     = {rbank, ridx};
    assign sending_data = (state != IDLE);

    // Close and release always hit different banks, so both updates merge safely.
    always_comb begin
        full_nxt = bank_full;
        if (close_bank)
            full_nxt[wbank] = 1'b1;
        if (release_bank)
            full_nxt[rbank] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|bank_full) state_nxt = SELECT;
            SELECT:  state_nxt = READ;
            READ:    if (rd_req && (ridx == idx_final)) state_nxt = RELEASE;
            RELEASE: state_nxt = full_nxt[~rbank] ? SELECT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Writer side: index, bank toggling, full flags and close ordering
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbank       <= 1'b0;
            widx        <= '0;
            bank_full   <= 2'b00;
            last_idx[0] <= '0;
            last_idx[1] <= '0;
            order       <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            bank_full <= full_nxt;
            if (drop)
                overflow <= 1'b1;
            if (close_bank) begin
                last_idx[wbank] <= write_ok ? widx : widx - IDX_ONE;
                widx            <= '0;
                wbank           <= ~wbank;
                // Only the first of two full banks becomes the oldest.
                if (!full_nxt[~wbank])
                    order <= wbank;
            end else if (write_ok) begin
                widx <= widx + IDX_ONE;
            end
        end
    end

    // Reader side: bank selection, read index, data-valid pipeline
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rbank     <= 1'b0;
            ridx      <= '0;
            idx_final <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= re;
            if (state == SELECT) begin
                rbank     <= sel_bank;
                ridx      <= '0;
                idx_final <= last_idx[sel_bank];
            end else if (re) begin
                ridx <= ridx + IDX_ONE;
            end
        end
    end

`ifdef BANK_ARB_DROP_CNT_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            drop_count <= 8'd0;
        else if (drop)
            drop_count <= sat_inc(drop_count);
    end
`endif

endmodule
